// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: segment patterns,
// display limit and the digit-index type.
package fnd_pkg;

  // Active-low segment patterns, bit 7 = dp (off), bits 6:0 = g..a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [13:0] MAX_VALUE = 14'd9999;

  typedef logic [1:0] digit_idx_t;

  // Saturate an input sample to the largest displayable value
  function automatic logic [13:0] clamp_value(input logic [13:0] v);
    return (v > MAX_VALUE) ? MAX_VALUE : v;
  endfunction

endpackage

// File: rtl/fnd_bcd_to_seg.sv
// Combinational decimal digit to active-low 7-segment (g..a) encoder.
// Codes above 9 blank the digit.
module fnd_bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Pattern lookup
  always_comb begin
    o_seg = SEG_BLANK[6:0];
    case (i_digit)
      4'd0:    o_seg = SEG_0[6:0];
      4'd1:    o_seg = SEG_1[6:0];
      4'd2:    o_seg = SEG_2[6:0];
      4'd3:    o_seg = SEG_3[6:0];
      4'd4:    o_seg = SEG_4[6:0];
      4'd5:    o_seg = SEG_5[6:0];
      4'd6:    o_seg = SEG_6[6:0];
      4'd7:    o_seg = SEG_7[6:0];
      4'd8:    o_seg = SEG_8[6:0];
      4'd9:    o_seg = SEG_9[6:0];
      default: o_seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit FND scan controller.
// Optional feature: define FND_DP_BLINK_EN to blink the digit-2 dp at 1 Hz
// (mm.ss separator); otherwise dp stays off.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_value,
  output logic [1:0]  fnd_sel,
  output logic [7:0]  fnd_data
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scan_tick;
  digit_idx_t       sel_q, sel_d;
  logic [13:0]      val_q, val_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       digit;
  logic [6:0]       seg;
  logic             dp_n;

  // Prescaler, scan counter and frame-coherent value latch
  always_comb begin
    scan_tick = (cnt_q == CNT_W'(DIV - 1));
    cnt_d     = scan_tick ? '0 : cnt_q + 1'b1;
    sel_d     = scan_tick ? sel_q + 2'd1 : sel_q;
    val_d     = (scan_tick && sel_q == 2'd3) ? clamp_value(i_value) : val_q;
  end

  // Digit selected by the next scan index, taken from the next latched
  // value, so the output register always matches fnd_sel
  always_comb begin
    digit = 4'd0;
    case (sel_d)
      2'd0: digit = 4'(val_d % 14'd10);
      2'd1: digit = 4'((val_d / 14'd10) % 14'd10);
      2'd2: digit = 4'((val_d / 14'd100) % 14'd10);
      2'd3: digit = 4'(val_d / 14'd1000);
      default: digit = 4'd0;
    endcase
  end

  fnd_bcd_to_seg u_bcd_to_seg (
    .i_digit (digit),
    .o_seg   (seg)
  );

`ifdef FND_DP_BLINK_EN
  localparam int unsigned BLINK_N = SCAN_HZ / 2;
  localparam int unsigned BLINK_W = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  // Blink phase toggles every SCAN_HZ/2 scan ticks; dp lit on digit 2
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (scan_tick) begin
      if (blink_cnt_q == BLINK_W'(BLINK_N - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    dp_n = ~(phase_d && sel_d == 2'd2);
  end

  // Blink state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  // dp permanently off
  always_comb begin
    dp_n = 1'b1;
  end
`endif

  // Output byte assembly
  always_comb begin
    data_d = {dp_n, seg};
  end

  // Scan state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      val_q  <= '0;
      data_q <= SEG_0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

  assign fnd_sel  = sel_q;
  assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with CLK_HZ=1000, SCAN_HZ=100 (DIV=10).
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [13:0] i_value;
  logic [1:0]  fnd_sel;
  logic [7:0]  fnd_data;

  int          nvec;
  int          nmis;
  int unsigned n;

  fnd_scan_ctrl #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_value  (i_value),
    .fnd_sel  (fnd_sel),
    .fnd_data (fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // One clock; checks scan index and dp bit against the cycle model
  task automatic step();
    logic [31:0] exp_sel;
    logic [31:0] exp_dp;
    @(posedge clk);
    n++;
    @(negedge clk);
    exp_sel = (n / 10) % 4;
    check_eq("sel", {30'd0, fnd_sel}, exp_sel);
`ifdef FND_DP_BLINK_EN
    exp_dp = (((n / 500) % 2 == 1) && exp_sel == 2) ? 32'd0 : 32'd1;
`else
    exp_dp = 32'd1;
`endif
    check_eq("dp", {31'd0, fnd_data[7]}, exp_dp);
  endtask

  task automatic run_to(input int unsigned t);
    while (n < t) step();
  endtask

  task automatic check_data(input string tag, input logic [7:0] exp);
    check_eq(tag, {24'd0, fnd_data}, {24'd0, exp});
  endtask

  initial begin
    nvec    = 0;
    nmis    = 0;
    n       = 0;
    reset   = 1'b1;
    i_value = 14'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_sel", {30'd0, fnd_sel}, 32'd0);
    check_data("rst_data", 8'hC0);
    reset = 1'b0;

    // First tick exactly DIV clocks after release
    run_to(9);
    check_eq("pre_tick_sel", {30'd0, fnd_sel}, 32'd0);
    run_to(10);
    check_eq("first_tick_sel", {30'd0, fnd_sel}, 32'd1);

    // Free-run cadence, "0000" until first capture
    run_to(80);
    check_data("idle_0000", 8'hC0);

    // 1234 captured at wrap edge 120
    i_value = 14'd1234;
    run_to(119); check_data("pre_wrap", 8'hC0);
    run_to(120); check_data("wrap_d0", 8'h99);
    run_to(125); check_data("1234_d0", 8'h99);
    run_to(135); check_data("1234_d1", 8'hB0);
    run_to(145); check_data("1234_d2", 8'hA4);
    run_to(155); check_data("1234_d3", 8'hF9);

    // Change mid-frame: rest of frame still 1234
    run_to(172); i_value = 14'd5678;
    run_to(175); check_data("coh_d1", 8'hB0);
    run_to(185); check_data("coh_d2", 8'hA4);
    run_to(195); check_data("coh_d3", 8'hF9);
    run_to(200); check_data("5678_d0", 8'h80);
    run_to(210); check_data("5678_d1", 8'hF8);
    run_to(220); check_data("5678_d2", 8'h82);
    run_to(230); check_data("5678_d3", 8'h92);

    // Change on the wrap edge itself, with clamp
    run_to(239); i_value = 14'd12000;
    run_to(240); check_data("clamp_d0", 8'h90);
    run_to(255); check_data("clamp_d1", 8'h90);
    run_to(265); check_data("clamp_d2", 8'h90);
    run_to(275); check_data("clamp_d3", 8'h90);

    // No leading-zero blanking
    run_to(279); i_value = 14'd7;
    run_to(285); check_data("0007_d0", 8'hF8);
    run_to(295); check_data("0007_d1", 8'hC0);
    run_to(305); check_data("0007_d2", 8'hC0);
    run_to(315); check_data("0007_d3", 8'hC0);

    i_value = 14'd4321;
    run_to(325); check_data("4321_d0", 8'hF9);
    run_to(335); check_data("4321_d1", 8'hA4);

    // Long run covers blink windows
    run_to(1135);
    check_data("pre_rst_d1", 8'hA4);
    check_eq("pre_rst_sel", {30'd0, fnd_sel}, 32'd1);

    // Asynchronous reset mid-digit, away from any clock edge
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_sel", {30'd0, fnd_sel}, 32'd0);
    check_data("async_rst_data", 8'hC0);
    repeat (2) @(negedge clk);
    check_eq("held_rst_sel", {30'd0, fnd_sel}, 32'd0);
    check_data("held_rst_data", 8'hC0);
    reset = 1'b0;
    n     = 0;
    run_to(9);
    check_eq("rerun_pre_tick", {30'd0, fnd_sel}, 32'd0);
    run_to(45);
    check_data("rerun_val_4321", 8'hF9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
